btb_train_ctrl: RTL and testbench
=================================

# btb_train_ctrl

Branch-resolution and BTB training controller sitting in ID, the write-side counterpart of the BTB. It records each IF-stage BTB prediction in a small in-order queue and pairs it with the branch outcome resolved in ID. It then drives the BTB update interface and issues a one-cycle redirect with the correct fetch PC on every misprediction. It also keeps branch and misprediction statistics.

## Interface
- QDEPTH, 4: prediction queue entries (power of two, 2..16)
- FLUSH_CYCLES, 1: cycles spent in FLUSH after a redirect (1..7)
- CLK  in  1  clock, all state on rising edge
- RESET  in  1  asynchronous, active-high; clears all state
- STALL  in  1  pipeline stall; freezes queue, FSM counter and statistics
- if_valid  in  1  IF holds a real fetch this cycle
- Instr_PC_IN_IF  in  32  PC fetched in IF
- hit_BTB_IN  in  1  BTB predicted taken for that PC
- pred_PC_IN_IF  in  32  BTB predicted target
- id_valid  in  1  ID holds a real instruction this cycle
- Instr_PC_IN_ID  in  32  PC of instruction in ID
- is_Branch_IN_ID  in  1  ID instruction is a branch/jump
- is_Taken_IN_ID  in  1  resolved direction
- Alt_PC_IN_ID  in  32  resolved target
- Instr_PC_OUT_ID  out  32  BTB update PC
- is_Branch_OUT_ID  out  1  BTB update: is branch
- is_Taken_OUT_ID  out  1  BTB update strobe, one-cycle pulse on a taken branch
- Alt_PC_OUT_ID  out  32  BTB update target
- redirect  out  1  one-cycle misprediction pulse
- redirect_PC  out  32  correct fetch PC, valid with redirect
- branch_count  out  32  resolved branches, saturating
- mispred_count  out  32  mispredictions, saturating
- train_drop_count  out  16  suppressed back-to-back taken updates, saturating
- q_overflow  out  1  sticky: a push was dropped because the queue was full

## Operation
- Reset values: all outputs 0, queue empty, FSM in RUN.
- Queue entry: {PC, hit, target}. Push when if_valid && !STALL && state==RUN.
- Pop head when id_valid && !STALL && state==RUN.
- Full with push and no pop: push dropped, q_overflow set. Full with push and pop: both occur.
- Pairing: the head is used when it is non-empty and its PC == Instr_PC_IN_ID. Otherwise the prediction is treated as hit=0, and the head is still popped if non-empty.
- Mispredict conditions:
  - is_Branch && (is_Taken != hit): redirect_PC = is_Taken ? Alt_PC : PC+8 (delay slot).
  - is_Branch && is_Taken && hit && target != Alt_PC: redirect_PC = Alt_PC.
  - !is_Branch && hit: redirect_PC = PC+8.
- Training: on every resolved branch, register Instr_PC_OUT_ID, is_Branch_OUT_ID=1 and Alt_PC_OUT_ID. These fields hold until the next update. is_Taken_OUT_ID pulses high for one cycle only if taken.
- is_Taken_OUT_ID must be low at least one cycle between pulses. A taken update resolved in the cycle right after a pulse has its strobe suppressed (fields still update) and increments train_drop_count.
- Statistics: branch_count += 1 per resolved branch; mispred_count += 1 per mispredict. Both saturate at all-ones.
- FSM:
  - RUN -> FLUSH on mispredict; the queue is cleared at the same edge.
  - FLUSH lasts FLUSH_CYCLES non-stalled cycles, then -> RUN.
  - In FLUSH, pushes, pops, training and statistics are ignored.
  - A mispredict in the last RUN cycle wins over a simultaneous push.

## Timing
- Resolution sampled at edge N; redirect, redirect_PC, update fields and strobe are valid N to N+1 (1-cycle latency, registered).
- redirect and is_Taken_OUT_ID are one-cycle pulses. STALL high forces both low the next cycle and blocks new ones.
- redirect_PC holds its last value when redirect is low.
- Push and pop in the same cycle: occupancy unchanged; the pop sees the pre-push head. Pointers wrap mod QDEPTH.
- RESET asserted mid-operation clears everything asynchronously. The first push can occur on the first edge after deassertion.

## Test plan
- Push PC 0x100 hit=0; resolve 0x100 branch taken Alt 0x200 -> next cycle redirect=1, redirect_PC=0x200, is_Taken_OUT_ID pulse, Instr_PC_OUT_ID=0x100, mispred_count=1.
- Push 0x100 hit=1 target 0x200; resolve taken to 0x200 -> no redirect, strobe pulses, branch_count=1, mispred_count=0.
- Push 0x100 hit=1 target 0x200; resolve not-taken -> redirect_PC=0x108, no strobe, queue empty afterwards, FLUSH ignores a push in the next cycle.
- Fill 4 entries, push a 5th without pop -> q_overflow=1. Then push+pop together -> occupancy stays 4 and head order is preserved across wrap.
- Taken branches resolved in consecutive cycles -> one strobe, train_drop_count=1, second PC still on Instr_PC_OUT_ID.
- Assert RESET during FLUSH with redirect high -> all outputs 0 immediately, FSM RUN, counters 0.

Source files
------------

// File: rtl/btb_train_ctrl_if.sv
// Bundle between the IF/ID pipeline and the BTB training controller.
// Latency: none, wires only.
// Backpressure: STALL travels with the bundle and freezes the controller.
interface btb_train_ctrl_if;
    // pipeline stall
    logic        STALL;
    // IF-stage prediction record
    logic        if_valid;
    logic [31:0] Instr_PC_IN_IF;
    logic        hit_BTB_IN;
    logic [31:0] pred_PC_IN_IF;
    // ID-stage resolution
    logic        id_valid;
    logic [31:0] Instr_PC_IN_ID;
    logic        is_Branch_IN_ID;
    logic        is_Taken_IN_ID;
    logic [31:0] Alt_PC_IN_ID;
    // BTB update port
    logic [31:0] Instr_PC_OUT_ID;
    logic        is_Branch_OUT_ID;
    logic        is_Taken_OUT_ID;
    logic [31:0] Alt_PC_OUT_ID;
    // redirect to fetch
    logic        redirect;
    logic [31:0] redirect_PC;
    // statistics
    logic [31:0] branch_count;
    logic [31:0] mispred_count;
    logic [15:0] train_drop_count;
    logic        q_overflow;

    // controller side
    modport slave (
        input  STALL, if_valid, Instr_PC_IN_IF, hit_BTB_IN, pred_PC_IN_IF,
               id_valid, Instr_PC_IN_ID, is_Branch_IN_ID, is_Taken_IN_ID, Alt_PC_IN_ID,
        output Instr_PC_OUT_ID, is_Branch_OUT_ID, is_Taken_OUT_ID, Alt_PC_OUT_ID,
               redirect, redirect_PC, branch_count, mispred_count, train_drop_count,
               q_overflow
    );

    // pipeline side
    modport master (
        output STALL, if_valid, Instr_PC_IN_IF, hit_BTB_IN, pred_PC_IN_IF,
               id_valid, Instr_PC_IN_ID, is_Branch_IN_ID, is_Taken_IN_ID, Alt_PC_IN_ID,
        input  Instr_PC_OUT_ID, is_Branch_OUT_ID, is_Taken_OUT_ID, Alt_PC_OUT_ID,
               redirect, redirect_PC, branch_count, mispred_count, train_drop_count,
               q_overflow
    );
endinterface

// File: rtl/btb_train_ctrl.sv
// Pairs queued IF-stage BTB predictions with ID-stage outcomes; trains the BTB, redirects fetch.
// Latency: 1 cycle from resolution edge to redirect / update outputs (all registered).
// Backpressure: STALL freezes queue, FSM and stats and forces both pulse outputs low.
module btb_train_ctrl #(
    parameter int QDEPTH       = 4,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    btb_train_ctrl_if.slave   bus
);
    localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t       state;
    logic [2:0]   flush_cnt;

    // prediction queue storage
    logic [31:0]  q_pc  [QDEPTH];
    logic         q_hit [QDEPTH];
    logic [31:0]  q_tgt [QDEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;
    logic         ovf_r;

    // registered outputs
    logic         redirect_r;
    logic [31:0]  redirect_pc_r;
    logic         strobe_r;
    logic         upd_branch_r;
    logic [31:0]  upd_pc_r;
    logic [31:0]  upd_alt_r;
    logic [31:0]  branch_cnt;
    logic [31:0]  mispred_cnt;
    logic [15:0]  drop_cnt;

    // decode of the current cycle
    logic         active;
    logic         head_vld;
    logic         full;
    logic         head_match;
    logic         pred_hit;
    logic [31:0]  pred_tgt;
    logic         resolve;
    logic         br;
    logic         tk;
    logic         mispred;
    logic [31:0]  fix_pc;
    logic         pop;
    logic         push_req;
    logic         push;
    logic         push_drop;
    logic         strobe_fire;
    logic         strobe_drop;

    assign active     = (state == RUN) && !bus.STALL;
    assign head_vld   = (count != '0);
    assign full       = (count == CW'(QDEPTH));
    assign head_match = head_vld && (q_pc[head] == bus.Instr_PC_IN_ID);
    // a missing or mismatched head counts as a not-taken prediction
    assign pred_hit   = head_match && q_hit[head];
    assign pred_tgt   = q_tgt[head];
    assign resolve    = active && bus.id_valid;
    assign br         = resolve && bus.is_Branch_IN_ID;
    assign tk         = bus.is_Taken_IN_ID;
    assign mispred    = resolve && (
                            (bus.is_Branch_IN_ID && (tk != pred_hit)) ||
                            (bus.is_Branch_IN_ID && tk && pred_hit && (pred_tgt != bus.Alt_PC_IN_ID)) ||
                            (!bus.is_Branch_IN_ID && pred_hit));
    // fall-through skips the delay slot
    assign fix_pc     = (bus.is_Branch_IN_ID && tk) ? bus.Alt_PC_IN_ID
                                                    : bus.Instr_PC_IN_ID + 32'd8;
    assign pop        = resolve && head_vld;
    assign push_req   = active && bus.if_valid;
    assign push       = push_req && (!full || pop);
    assign push_drop  = push_req && full && !pop;
    // strobe needs a low cycle between pulses
    assign strobe_fire = br && tk && !strobe_r;
    assign strobe_drop = br && tk && strobe_r;

    // in-order prediction queue; a mispredict flushes it and beats any push
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            ovf_r <= 1'b0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_pc[i]  <= '0;
                q_hit[i] <= 1'b0;
                q_tgt[i] <= '0;
            end
        end else if (mispred) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                q_pc[tail]  <= bus.Instr_PC_IN_IF;
                q_hit[tail] <= bus.hit_BTB_IN;
                q_tgt[tail] <= bus.pred_PC_IN_IF;
                tail        <= tail + AW'(1);
            end
            if (pop) begin
                head <= head + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
            if (push_drop) begin
                ovf_r <= 1'b1;
            end
        end
    end

    // RUN/FLUSH sequencing; FLUSH counts only non-stalled cycles
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= RUN;
            flush_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (mispred) begin
                        state     <= FLUSH;
                        flush_cnt <= '0;
                    end
                end
                FLUSH: begin
                    if (!bus.STALL) begin
                        if (flush_cnt == 3'(FLUSH_CYCLES - 1)) begin
                            state <= RUN;
                        end else begin
                            flush_cnt <= flush_cnt + 3'd1;
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // redirect pulse and BTB update fields; pulses default low every cycle
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            redirect_r    <= 1'b0;
            redirect_pc_r <= '0;
            strobe_r      <= 1'b0;
            upd_branch_r  <= 1'b0;
            upd_pc_r      <= '0;
            upd_alt_r     <= '0;
        end else begin
            redirect_r <= mispred;
            strobe_r   <= strobe_fire;
            if (mispred) begin
                redirect_pc_r <= fix_pc;
            end
            if (br) begin
                upd_branch_r <= 1'b1;
                upd_pc_r     <= bus.Instr_PC_IN_ID;
                upd_alt_r    <= bus.Alt_PC_IN_ID;
            end
        end
    end

    // saturating statistics
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
            drop_cnt    <= '0;
        end else begin
            if (br && (branch_cnt != '1)) begin
                branch_cnt <= branch_cnt + 32'd1;
            end
            if (mispred && (mispred_cnt != '1)) begin
                mispred_cnt <= mispred_cnt + 32'd1;
            end
            if (strobe_drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    assign bus.redirect         = redirect_r;
    assign bus.redirect_PC      = redirect_pc_r;
    assign bus.is_Taken_OUT_ID  = strobe_r;
    assign bus.is_Branch_OUT_ID = upd_branch_r;
    assign bus.Instr_PC_OUT_ID  = upd_pc_r;
    assign bus.Alt_PC_OUT_ID    = upd_alt_r;
    assign bus.branch_count     = branch_cnt;
    assign bus.mispred_count    = mispred_cnt;
    assign bus.train_drop_count = drop_cnt;
    assign bus.q_overflow       = ovf_r;
endmodule

// File: tb/tb_btb_train_ctrl.sv
// Directed bench for btb_train_ctrl: vector table plus hand sequences.
// Inputs driven at negedge, outputs sampled 1 ns after posedge.
// Covers pairing, mispredict kinds, FLUSH, strobe spacing, overflow/wrap, stall, async reset.
module tb_btb_train_ctrl;
    logic CLK;
    logic RESET;
    int   checks;
    int   errors;

    btb_train_ctrl_if bus ();

    btb_train_ctrl #(.QDEPTH(4), .FLUSH_CYCLES(1)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        iv;
        logic [31:0] ipc;
        logic        ih;
        logic [31:0] itg;
        logic        dv;
        logic [31:0] dpc;
        logic        db;
        logic        dt;
        logic [31:0] dalt;
        logic        st;
        logic        e_rd;
        logic [31:0] e_rpc;
        logic        e_stb;
        logic [31:0] e_opc;
        logic [31:0] e_bc;
        logic [31:0] e_mc;
        logic [31:0] e_dc;
        logic        e_ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk_in(input logic iv, input logic [31:0] ipc, input logic ih,
                                   input logic [31:0] itg, input logic dv, input logic [31:0] dpc,
                                   input logic db, input logic dt, input logic [31:0] dalt,
                                   input logic st);
        vec_t v;
        v.iv = iv; v.ipc = ipc; v.ih = ih; v.itg = itg;
        v.dv = dv; v.dpc = dpc; v.db = db; v.dt = dt; v.dalt = dalt; v.st = st;
        v.e_rd = 0; v.e_rpc = 0; v.e_stb = 0; v.e_opc = 0;
        v.e_bc = 0; v.e_mc = 0; v.e_dc = 0; v.e_ovf = 0;
        return v;
    endfunction

    function automatic vec_t ex(input vec_t vi, input logic rd, input logic [31:0] rpc,
                                input logic stb, input logic [31:0] opc, input logic [31:0] bc,
                                input logic [31:0] mc, input logic [31:0] dc, input logic ovf);
        vec_t v;
        v = vi;
        v.e_rd = rd; v.e_rpc = rpc; v.e_stb = stb; v.e_opc = opc;
        v.e_bc = bc; v.e_mc = mc; v.e_dc = dc; v.e_ovf = ovf;
        return v;
    endfunction

    function automatic vec_t idle();
        return mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic vec_t push(input logic [31:0] pc, input logic h, input logic [31:0] tg);
        return mk_in(1, pc, h, tg, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic vec_t res(input logic [31:0] pc, input logic b, input logic t,
                                 input logic [31:0] alt);
        return mk_in(0, 0, 0, 0, 1, pc, b, t, alt, 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_in(input vec_t v);
        bus.if_valid        = v.iv;
        bus.Instr_PC_IN_IF  = v.ipc;
        bus.hit_BTB_IN      = v.ih;
        bus.pred_PC_IN_IF   = v.itg;
        bus.id_valid        = v.dv;
        bus.Instr_PC_IN_ID  = v.dpc;
        bus.is_Branch_IN_ID = v.db;
        bus.is_Taken_IN_ID  = v.dt;
        bus.Alt_PC_IN_ID    = v.dalt;
        bus.STALL           = v.st;
    endtask

    task automatic apply(input vec_t v);
        @(negedge CLK);
        set_in(v);
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " redirect"},    {31'd0, bus.redirect}, 0);
        chk({tag, " redirect_PC"}, bus.redirect_PC, 0);
        chk({tag, " strobe"},      {31'd0, bus.is_Taken_OUT_ID}, 0);
        chk({tag, " is_branch"},   {31'd0, bus.is_Branch_OUT_ID}, 0);
        chk({tag, " upd_pc"},      bus.Instr_PC_OUT_ID, 0);
        chk({tag, " upd_alt"},     bus.Alt_PC_OUT_ID, 0);
        chk({tag, " branch_cnt"},  bus.branch_count, 0);
        chk({tag, " mispred_cnt"}, bus.mispred_count, 0);
        chk({tag, " drop_cnt"},    {16'd0, bus.train_drop_count}, 0);
        chk({tag, " overflow"},    {31'd0, bus.q_overflow}, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RESET  = 1'b1;
        set_in(idle());

        // vector table: {inputs} -> {redirect, redirect_PC, strobe, upd_pc, bc, mc, drop, ovf}
        // mispredict on a taken branch with no BTB hit
        tbl.push_back(ex(push('h100, 0, 0),            0, 'h000, 0, 'h000, 0, 0, 0, 0));
        tbl.push_back(ex(res('h100, 1, 1, 'h200),      1, 'h200, 1, 'h100, 1, 1, 0, 0));
        tbl.push_back(ex(idle(),                       0, 'h200, 0, 'h100, 1, 1, 0, 0));
        // correct taken prediction
        tbl.push_back(ex(push('h100, 1, 'h200),        0, 'h200, 0, 'h100, 1, 1, 0, 0));
        tbl.push_back(ex(res('h100, 1, 1, 'h200),      0, 'h200, 1, 'h100, 2, 1, 0, 0));
        // predicted taken, resolved not-taken; push during FLUSH is lost
        tbl.push_back(ex(push('h100, 1, 'h200),        0, 'h200, 0, 'h100, 2, 1, 0, 0));
        tbl.push_back(ex(res('h100, 1, 0, 'h200),      1, 'h108, 0, 'h100, 3, 2, 0, 0));
        tbl.push_back(ex(push('h300, 1, 'h400),        0, 'h108, 0, 'h100, 3, 2, 0, 0));
        tbl.push_back(ex(res('h300, 1, 1, 'h400),      1, 'h400, 1, 'h300, 4, 3, 0, 0));
        tbl.push_back(ex(idle(),                       0, 'h400, 0, 'h300, 4, 3, 0, 0));
        // BTB hit on a non-branch
        tbl.push_back(ex(push('h500, 1, 'h600),        0, 'h400, 0, 'h300, 4, 3, 0, 0));
        tbl.push_back(ex(res('h500, 0, 0, 0),          1, 'h508, 0, 'h300, 4, 4, 0, 0));
        tbl.push_back(ex(idle(),                       0, 'h508, 0, 'h300, 4, 4, 0, 0));
        // wrong predicted target
        tbl.push_back(ex(push('h700, 1, 'h800),        0, 'h508, 0, 'h300, 4, 4, 0, 0));
        tbl.push_back(ex(res('h700, 1, 1, 'h900),      1, 'h900, 1, 'h700, 5, 5, 0, 0));
        tbl.push_back(ex(idle(),                       0, 'h900, 0, 'h700, 5, 5, 0, 0));
        // head PC mismatch: treated as no hit, head still popped
        tbl.push_back(ex(push('hA00, 1, 'hB00),        0, 'h900, 0, 'h700, 5, 5, 0, 0));
        tbl.push_back(ex(res('hC00, 1, 0, 'hD00),      0, 'h900, 0, 'hC00, 6, 5, 0, 0));
        tbl.push_back(ex(res('hA00, 1, 1, 'hB00),      1, 'hB00, 1, 'hA00, 7, 6, 0, 0));
        tbl.push_back(ex(idle(),                       0, 'hB00, 0, 'hA00, 7, 6, 0, 0));
        // push+pop same cycle, then back-to-back taken updates
        tbl.push_back(ex(push('h1000, 1, 'h1100),      0, 'hB00, 0, 'hA00, 7, 6, 0, 0));
        tbl.push_back(ex(mk_in(1, 'h2000, 1, 'h2100, 1, 'h1000, 1, 1, 'h1100, 0),
                                                       0, 'hB00, 1, 'h1000, 8, 6, 0, 0));
        tbl.push_back(ex(res('h2000, 1, 1, 'h2100),    0, 'hB00, 0, 'h2000, 9, 6, 1, 0));
        tbl.push_back(ex(idle(),                       0, 'hB00, 0, 'h2000, 9, 6, 1, 0));
        // stall blocks a resolution; it lands once the stall drops
        tbl.push_back(ex(push('h3000, 1, 'h3100),      0, 'hB00, 0, 'h2000, 9, 6, 1, 0));
        tbl.push_back(ex(mk_in(0, 0, 0, 0, 1, 'h3000, 1, 1, 'h3100, 1),
                                                       0, 'hB00, 0, 'h2000, 9, 6, 1, 0));
        tbl.push_back(ex(res('h3000, 1, 1, 'h3100),    0, 'hB00, 1, 'h3000, 10, 6, 1, 0));

        // reset values
        repeat (2) @(posedge CLK);
        #1;
        chk_all_zero("reset");
        @(negedge CLK);
        RESET = 1'b0;

        foreach (tbl[i]) begin
            apply(tbl[i]);
            chk($sformatf("v%0d redirect", i),    {31'd0, bus.redirect}, {31'd0, tbl[i].e_rd});
            chk($sformatf("v%0d redirect_PC", i), bus.redirect_PC, tbl[i].e_rpc);
            chk($sformatf("v%0d strobe", i),      {31'd0, bus.is_Taken_OUT_ID}, {31'd0, tbl[i].e_stb});
            chk($sformatf("v%0d upd_pc", i),      bus.Instr_PC_OUT_ID, tbl[i].e_opc);
            chk($sformatf("v%0d branch_cnt", i),  bus.branch_count, tbl[i].e_bc);
            chk($sformatf("v%0d mispred_cnt", i), bus.mispred_count, tbl[i].e_mc);
            chk($sformatf("v%0d drop_cnt", i),    {16'd0, bus.train_drop_count}, tbl[i].e_dc);
            chk($sformatf("v%0d overflow", i),    {31'd0, bus.q_overflow}, {31'd0, tbl[i].e_ovf});
        end
        chk("upd_alt", bus.Alt_PC_OUT_ID, 'h3100);
        chk("is_branch", {31'd0, bus.is_Branch_OUT_ID}, 1);

        // fill the queue, overflow it, then push+pop across the pointer wrap
        for (int k = 1; k <= 4; k++) begin
            apply(push(32'(k * 'h10), 1, 32'(k * 'h10 + 4)));
        end
        chk("fill overflow", {31'd0, bus.q_overflow}, 0);
        apply(push('h50, 1, 'h54));
        chk("overflow set", {31'd0, bus.q_overflow}, 1);
        apply(mk_in(1, 'h60, 1, 'h64, 1, 'h10, 1, 1, 'h14, 0));
        chk("wrap pop 0x10", {31'd0, bus.redirect}, 0);
        apply(res('h20, 1, 1, 'h24));
        chk("wrap pop 0x20", {31'd0, bus.redirect}, 0);
        apply(res('h30, 1, 1, 'h34));
        chk("wrap pop 0x30", {31'd0, bus.redirect}, 0);
        apply(res('h40, 1, 1, 'h44));
        chk("wrap pop 0x40", {31'd0, bus.redirect}, 0);
        apply(res('h60, 1, 1, 'h64));
        chk("wrap pop 0x60", {31'd0, bus.redirect}, 0);
        chk("wrap mispred_cnt", bus.mispred_count, 6);
        // 0x50 was dropped, so the queue is empty and this mispredicts
        apply(res('h50, 1, 1, 'h54));
        chk("dropped redirect", {31'd0, bus.redirect}, 1);
        chk("dropped redirect_PC", bus.redirect_PC, 'h54);
        chk("dropped mispred_cnt", bus.mispred_count, 7);
        chk("overflow sticky", {31'd0, bus.q_overflow}, 1);

        // asynchronous reset while in FLUSH with redirect high
        #1;
        RESET = 1'b1;
        #1;
        chk_all_zero("async reset");
        @(negedge CLK);
        RESET = 1'b0;
        set_in(push('h900, 1, 'h904));
        @(posedge CLK);
        #1;
        apply(res('h900, 1, 1, 'h904));
        chk("post-reset redirect", {31'd0, bus.redirect}, 0);
        chk("post-reset strobe", {31'd0, bus.is_Taken_OUT_ID}, 1);
        chk("post-reset branch_cnt", bus.branch_count, 1);
        chk("post-reset mispred_cnt", bus.mispred_count, 0);
        chk("post-reset upd_pc", bus.Instr_PC_OUT_ID, 'h900);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
